// File: rtl/e203_dtcm_rr_arbt.sv
// Two-requester round-robin arbiter in front of the DTCM SRAM controller.
// At most one transaction is outstanding. A new command may issue in the
// same cycle the outstanding response completes, so back-to-back traffic
// sustains one transaction per cycle.
module e203_dtcm_rr_arbt #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  // requester 0 (LSU)
  input  logic          r0_cmd_valid,
  output logic          r0_cmd_ready,
  input  logic          r0_cmd_read,
  input  logic [AW-1:0] r0_cmd_addr,
  input  logic [DW-1:0] r0_cmd_wdata,
  input  logic [MW-1:0] r0_cmd_wmask,
  output logic          r0_rsp_valid,
  input  logic          r0_rsp_ready,
  output logic          r0_rsp_err,
  output logic [DW-1:0] r0_rsp_rdata,
  // requester 1 (external agent)
  input  logic          r1_cmd_valid,
  output logic          r1_cmd_ready,
  input  logic          r1_cmd_read,
  input  logic [AW-1:0] r1_cmd_addr,
  input  logic [DW-1:0] r1_cmd_wdata,
  input  logic [MW-1:0] r1_cmd_wmask,
  output logic          r1_rsp_valid,
  input  logic          r1_rsp_ready,
  output logic          r1_rsp_err,
  output logic [DW-1:0] r1_rsp_rdata,
  // DTCM controller side
  output logic          o_cmd_valid,
  input  logic          o_cmd_ready,
  output logic          o_cmd_read,
  output logic [AW-1:0] o_cmd_addr,
  output logic [DW-1:0] o_cmd_wdata,
  output logic [MW-1:0] o_cmd_wmask,
  input  logic          o_rsp_valid,
  output logic          o_rsp_ready,
  input  logic          o_rsp_err,
  input  logic [DW-1:0] o_rsp_rdata,
  // status
  output logic          arbt_active,
  output logic          proto_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t state;
  logic   owner;     // requester of the outstanding command
  logic   last_gnt;  // requester most recently granted
  logic   lock_vld;  // a command was presented but stalled last cycle
  logic   lock_sel;  // which requester that stalled command came from
  logic   sel;
  logic   sel_vld;
  logic   win;
  logic   rsp_hs;
  logic   cmd_hs;

  // Response path: the owner sees the controller's response while in WAIT;
  // in IDLE anything arriving is drained and flagged.
  assign o_rsp_ready  = (state == IDLE) ? 1'b1 : (owner ? r1_rsp_ready : r0_rsp_ready);
  assign rsp_hs       = (state == WAIT) & o_rsp_valid & o_rsp_ready;
  assign r0_rsp_valid = ~rst & (state == WAIT) & ~owner & o_rsp_valid;
  assign r1_rsp_valid = ~rst & (state == WAIT) &  owner & o_rsp_valid;
  assign r0_rsp_rdata = o_rsp_rdata;
  assign r1_rsp_rdata = o_rsp_rdata;
  assign r0_rsp_err   = o_rsp_err;
  assign r1_rsp_err   = o_rsp_err;

  // A new command may go out when idle or when the outstanding one retires now.
  assign win = (state == IDLE) | rsp_hs;

  // Round-robin pick; a stalled presentation keeps its requester until it
  // is accepted or that requester withdraws, so the command never switches
  // under a stalled controller.
  always_comb begin
    sel = 1'b0;
    if (lock_vld && (lock_sel ? r1_cmd_valid : r0_cmd_valid))
      sel = lock_sel;
    else if (r0_cmd_valid && r1_cmd_valid)
      sel = ~last_gnt;
    else if (r1_cmd_valid)
      sel = 1'b1;
  end

  assign sel_vld      = sel ? r1_cmd_valid : r0_cmd_valid;
  assign o_cmd_valid  = ~rst & win & sel_vld;
  assign o_cmd_read   = sel ? r1_cmd_read  : r0_cmd_read;
  assign o_cmd_addr   = sel ? r1_cmd_addr  : r0_cmd_addr;
  assign o_cmd_wdata  = sel ? r1_cmd_wdata : r0_cmd_wdata;
  assign o_cmd_wmask  = sel ? r1_cmd_wmask : r0_cmd_wmask;
  assign r0_cmd_ready = ~rst & win & ~sel & o_cmd_ready;
  assign r1_cmd_ready = ~rst & win &  sel & o_cmd_ready;
  assign cmd_hs       = o_cmd_valid & o_cmd_ready;

  assign arbt_active  = r0_cmd_valid | r1_cmd_valid | (state == WAIT);

  // Arbiter state, ownership, round-robin pointer, stall lock and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      lock_vld  <= 1'b0;
      lock_sel  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      lock_vld <= o_cmd_valid & ~o_cmd_ready;
      lock_sel <= sel;
      if ((state == IDLE) && o_rsp_valid)
        proto_err <= 1'b1;
      if (cmd_hs) begin
        state    <= WAIT;
        owner    <= sel;
        last_gnt <= sel;
      end else if (rsp_hs) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_e203_dtcm_rr_arbt.sv
// Bench for the DTCM round-robin arbiter: grant order, data steering,
// stall stability, response backpressure, drain error and mid-flight reset.
module tb_e203_dtcm_rr_arbt;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_cmd_valid, r0_cmd_ready, r0_cmd_read;
  logic [AW-1:0] r0_cmd_addr;
  logic [DW-1:0] r0_cmd_wdata;
  logic [MW-1:0] r0_cmd_wmask;
  logic          r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
  logic [DW-1:0] r0_rsp_rdata;
  logic          r1_cmd_valid, r1_cmd_ready, r1_cmd_read;
  logic [AW-1:0] r1_cmd_addr;
  logic [DW-1:0] r1_cmd_wdata;
  logic [MW-1:0] r1_cmd_wmask;
  logic          r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
  logic [DW-1:0] r1_rsp_rdata;
  logic          o_cmd_valid, o_cmd_ready, o_cmd_read;
  logic [AW-1:0] o_cmd_addr;
  logic [DW-1:0] o_cmd_wdata;
  logic [MW-1:0] o_cmd_wmask;
  logic          o_rsp_valid, o_rsp_ready, o_rsp_err;
  logic [DW-1:0] o_rsp_rdata;
  logic          arbt_active, proto_err;

  int vecs = 0;
  int errs = 0;
  int exp_gnt[$];
  int exp_rsp[$];
  logic [DW-1:0] exp_data[$];

  always #5 clk = ~clk;

  e203_dtcm_rr_arbt #(.AW(AW), .DW(DW), .MW(MW)) dut (
    .clk(clk), .rst(rst),
    .r0_cmd_valid(r0_cmd_valid), .r0_cmd_ready(r0_cmd_ready), .r0_cmd_read(r0_cmd_read),
    .r0_cmd_addr(r0_cmd_addr), .r0_cmd_wdata(r0_cmd_wdata), .r0_cmd_wmask(r0_cmd_wmask),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_err(r0_rsp_err),
    .r0_rsp_rdata(r0_rsp_rdata),
    .r1_cmd_valid(r1_cmd_valid), .r1_cmd_ready(r1_cmd_ready), .r1_cmd_read(r1_cmd_read),
    .r1_cmd_addr(r1_cmd_addr), .r1_cmd_wdata(r1_cmd_wdata), .r1_cmd_wmask(r1_cmd_wmask),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_err(r1_rsp_err),
    .r1_rsp_rdata(r1_rsp_rdata),
    .o_cmd_valid(o_cmd_valid), .o_cmd_ready(o_cmd_ready), .o_cmd_read(o_cmd_read),
    .o_cmd_addr(o_cmd_addr), .o_cmd_wdata(o_cmd_wdata), .o_cmd_wmask(o_cmd_wmask),
    .o_rsp_valid(o_rsp_valid), .o_rsp_ready(o_rsp_ready), .o_rsp_err(o_rsp_err),
    .o_rsp_rdata(o_rsp_rdata),
    .arbt_active(arbt_active), .proto_err(proto_err)
  );

  task automatic idle_inputs();
    r0_cmd_valid = 0; r0_cmd_read = 1; r0_cmd_addr = '0; r0_cmd_wdata = '0; r0_cmd_wmask = '0;
    r1_cmd_valid = 0; r1_cmd_read = 1; r1_cmd_addr = '0; r1_cmd_wdata = '0; r1_cmd_wmask = '0;
    r0_rsp_ready = 1; r1_rsp_ready = 1;
    o_cmd_ready = 1; o_rsp_valid = 0; o_rsp_err = 0; o_rsp_rdata = '0;
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    r0_cmd_valid = 1; r1_cmd_valid = 1; o_rsp_valid = 1;
    #2;
    vecs++;
    if (o_cmd_valid !== 1'b0 || r0_cmd_ready !== 1'b0 || r1_cmd_ready !== 1'b0) begin
      errs++; $display("FAIL reset_cmd: o_cmd_valid=%b r0_rdy=%b r1_rdy=%b want 0 0 0",
                       o_cmd_valid, r0_cmd_ready, r1_cmd_ready);
    end
    vecs++;
    if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0 || proto_err !== 1'b0) begin
      errs++; $display("FAIL reset_rsp: r0_rv=%b r1_rv=%b perr=%b want 0 0 0",
                       r0_rsp_valid, r1_rsp_valid, proto_err);
    end
    step(); step();
    vecs++;
    if (o_cmd_valid !== 1'b0 || proto_err !== 1'b0) begin
      errs++; $display("FAIL reset_held: o_cmd_valid=%b perr=%b want 0 0", o_cmd_valid, proto_err);
    end
    idle_inputs();
    rst = 0;
    step();
    vecs++;
    if (arbt_active !== 1'b0) begin
      errs++; $display("FAIL reset_active: got %b want 0", arbt_active);
    end
  endtask

  // Both requesters always valid; responses return one cycle after the grant.
  task automatic test_round_robin();
    int grants = 0;
    int e, got;
    logic [AW-1:0] ea;
    exp_gnt.delete(); exp_rsp.delete();
    for (int i = 0; i < 8; i++) exp_gnt.push_back(i % 2);
    r0_cmd_valid = 1; r0_cmd_addr = 16'h0100;
    r1_cmd_valid = 1; r1_cmd_addr = 16'h0200;
    for (int c = 0; c < 14 && (grants < 8 || exp_rsp.size() > 0); c++) begin
      o_rsp_valid = (exp_rsp.size() > 0);
      o_rsp_rdata = 32'hA000_0000 + c;
      if (grants >= 8) begin r0_cmd_valid = 0; r1_cmd_valid = 0; end
      #2;
      if (o_rsp_valid && o_rsp_ready) begin
        e = exp_rsp.pop_front();
        got = (r0_rsp_valid && r1_rsp_valid) ? 3 : r0_rsp_valid ? 0 : r1_rsp_valid ? 1 : 2;
        vecs++;
        if (got !== e || r0_rsp_rdata !== o_rsp_rdata || r1_rsp_rdata !== o_rsp_rdata) begin
          errs++; $display("FAIL rr_rsp: cycle %0d got requester %0d want %0d", c, got, e);
        end
      end
      if (o_cmd_valid && o_cmd_ready) begin
        got = (r0_cmd_ready && r1_cmd_ready) ? 3 : r0_cmd_ready ? 0 : r1_cmd_ready ? 1 : 2;
        vecs++;
        if (exp_gnt.size() == 0) begin
          errs++; $display("FAIL rr_extra_gnt: cycle %0d got requester %0d want none", c, got);
        end else begin
          e = exp_gnt.pop_front();
          ea = (e == 1) ? 16'h0200 : 16'h0100;
          if (got !== e || o_cmd_addr !== ea) begin
            errs++; $display("FAIL rr_gnt: grant %0d got req %0d addr %h want req %0d addr %h",
                             grants, got, o_cmd_addr, e, ea);
          end
          exp_rsp.push_back(e);
        end
        grants++;
      end
      step();
    end
    o_rsp_valid = 0;
    vecs++;
    if (grants !== 8 || exp_gnt.size() !== 0 || exp_rsp.size() !== 0) begin
      errs++; $display("FAIL rr_count: grants %0d pending %0d/%0d want 8 0/0",
                       grants, exp_gnt.size(), exp_rsp.size());
    end
    #1;
    vecs++;
    if (arbt_active !== 1'b0) begin
      errs++; $display("FAIL rr_idle: arbt_active %b want 0", arbt_active);
    end
  endtask

  // r1 read with data steering, then an r0 write (leaves last_gnt at r0).
  task automatic test_r1_read_r0_write();
    logic [DW-1:0] ed;
    idle_inputs();
    r1_cmd_valid = 1; r1_cmd_read = 1; r1_cmd_addr = 16'h0040;
    #2;
    vecs++;
    if (o_cmd_valid !== 1'b1 || o_cmd_addr !== 16'h0040 || o_cmd_read !== 1'b1 ||
        r1_cmd_ready !== 1'b1 || r0_cmd_ready !== 1'b0) begin
      errs++; $display("FAIL r1_cmd: v=%b addr=%h rd=%b r1rdy=%b r0rdy=%b want 1 0040 1 1 0",
                       o_cmd_valid, o_cmd_addr, o_cmd_read, r1_cmd_ready, r0_cmd_ready);
    end
    exp_data.push_back(32'hDEADBEEF);
    step();
    r1_cmd_valid = 0; o_rsp_valid = 1; o_rsp_rdata = 32'hDEADBEEF;
    #2;
    ed = exp_data.pop_front();
    vecs++;
    if (r1_rsp_valid !== 1'b1 || r1_rsp_rdata !== ed || r0_rsp_valid !== 1'b0) begin
      errs++; $display("FAIL r1_rsp: r1_rv=%b data=%h r0_rv=%b want 1 %h 0",
                       r1_rsp_valid, r1_rsp_rdata, r0_rsp_valid, ed);
    end
    step();
    o_rsp_valid = 0;
    r0_cmd_valid = 1; r0_cmd_read = 0; r0_cmd_addr = 16'h0088;
    r0_cmd_wdata = 32'h1234_5678; r0_cmd_wmask = 4'b0110;
    r1_cmd_wdata = 32'hFFFF_0000; r1_cmd_wmask = 4'b1001;
    #2;
    vecs++;
    if (o_cmd_read !== 1'b0 || o_cmd_wdata !== 32'h1234_5678 || o_cmd_wmask !== 4'b0110 ||
        r0_cmd_ready !== 1'b1) begin
      errs++; $display("FAIL r0_wr: rd=%b wdata=%h wmask=%b rdy=%b want 0 12345678 0110 1",
                       o_cmd_read, o_cmd_wdata, o_cmd_wmask, r0_cmd_ready);
    end
    step();
    r0_cmd_valid = 0; o_rsp_valid = 1; o_rsp_err = 1;
    #2;
    vecs++;
    if (r0_rsp_valid !== 1'b1 || r0_rsp_err !== 1'b1 || r1_rsp_valid !== 1'b0) begin
      errs++; $display("FAIL r0_wr_rsp: r0_rv=%b err=%b r1_rv=%b want 1 1 0",
                       r0_rsp_valid, r0_rsp_err, r1_rsp_valid);
    end
    step();
    idle_inputs();
  endtask

  // r0 stalled 3 cycles; r1 arrives mid-stall and must not take over.
  task automatic test_stall();
    r0_cmd_valid = 1; r0_cmd_addr = 16'h0123;
    r1_cmd_addr = 16'h0456;
    o_cmd_ready = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) r1_cmd_valid = 1;
      #2;
      vecs++;
      if (o_cmd_valid !== 1'b1 || o_cmd_addr !== 16'h0123 ||
          r0_cmd_ready !== 1'b0 || r1_cmd_ready !== 1'b0) begin
        errs++; $display("FAIL stall_hold: k=%0d v=%b addr=%h rdy=%b%b want 1 0123 00",
                         k, o_cmd_valid, o_cmd_addr, r0_cmd_ready, r1_cmd_ready);
      end
      step();
    end
    o_cmd_ready = 1;
    #2;
    vecs++;
    if (r0_cmd_ready !== 1'b1 || r1_cmd_ready !== 1'b0 || o_cmd_addr !== 16'h0123) begin
      errs++; $display("FAIL stall_accept: rdy=%b%b addr=%h want r0 0123",
                       r0_cmd_ready, r1_cmd_ready, o_cmd_addr);
    end
    step();
    r0_cmd_valid = 0; o_rsp_valid = 1;
    #2;
    vecs++;
    if (r0_rsp_valid !== 1'b1 || r1_cmd_ready !== 1'b1 || o_cmd_addr !== 16'h0456) begin
      errs++; $display("FAIL stall_b2b: r0_rv=%b r1rdy=%b addr=%h want 1 1 0456",
                       r0_rsp_valid, r1_cmd_ready, o_cmd_addr);
    end
    step();
    r1_cmd_valid = 0;
    #2;
    vecs++;
    if (r1_rsp_valid !== 1'b1 || r0_rsp_valid !== 1'b0) begin
      errs++; $display("FAIL stall_r1_rsp: r1_rv=%b r0_rv=%b want 1 0", r1_rsp_valid, r0_rsp_valid);
    end
    step();
    idle_inputs();
  endtask

  // Owner r0 holds off its response for 2 cycles; r1 waits meanwhile.
  task automatic test_rsp_backpressure();
    r0_cmd_valid = 1; r0_cmd_addr = 16'h0010;
    #2;
    vecs++;
    if (r0_cmd_ready !== 1'b1) begin
      errs++; $display("FAIL bp_gnt: r0_rdy=%b want 1", r0_cmd_ready);
    end
    step();
    r0_cmd_valid = 0; r1_cmd_valid = 1; r1_cmd_addr = 16'h0020;
    r0_rsp_ready = 0; o_rsp_valid = 1;
    for (int k = 0; k < 2; k++) begin
      #2;
      vecs++;
      if (o_rsp_ready !== 1'b0 || o_cmd_valid !== 1'b0 || r1_cmd_ready !== 1'b0 ||
          r0_rsp_valid !== 1'b1) begin
        errs++; $display("FAIL bp_hold: k=%0d ordy=%b ocv=%b r1rdy=%b r0rv=%b want 0 0 0 1",
                         k, o_rsp_ready, o_cmd_valid, r1_cmd_ready, r0_rsp_valid);
      end
      step();
    end
    r0_rsp_ready = 1;
    #2;
    vecs++;
    if (o_rsp_ready !== 1'b1 || r1_cmd_ready !== 1'b1) begin
      errs++; $display("FAIL bp_release: ordy=%b r1rdy=%b want 1 1", o_rsp_ready, r1_cmd_ready);
    end
    step();
    r1_cmd_valid = 0;
    #2;
    vecs++;
    if (r1_rsp_valid !== 1'b1) begin
      errs++; $display("FAIL bp_r1_rsp: r1_rv=%b want 1", r1_rsp_valid);
    end
    step();
    idle_inputs();
    #1;
    vecs++;
    if (arbt_active !== 1'b0) begin
      errs++; $display("FAIL bp_idle: arbt_active=%b want 0", arbt_active);
    end
  endtask

  task automatic test_proto_err();
    o_rsp_valid = 1;
    #2;
    vecs++;
    if (proto_err !== 1'b0 || o_rsp_ready !== 1'b1 || r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin
      errs++; $display("FAIL perr_drain: perr=%b ordy=%b rv=%b%b want 0 1 00",
                       proto_err, o_rsp_ready, r0_rsp_valid, r1_rsp_valid);
    end
    step();
    o_rsp_valid = 0;
    vecs++;
    if (proto_err !== 1'b1) begin
      errs++; $display("FAIL perr_set: got %b want 1", proto_err);
    end
    step(); step(); step();
    vecs++;
    if (proto_err !== 1'b1) begin
      errs++; $display("FAIL perr_sticky: got %b want 1", proto_err);
    end
  endtask

  task automatic test_reset_mid();
    r0_cmd_valid = 1; r0_cmd_addr = 16'h0300;
    step();
    r0_cmd_valid = 0;
    #1;
    vecs++;
    if (arbt_active !== 1'b1) begin
      errs++; $display("FAIL rm_wait: arbt_active=%b want 1", arbt_active);
    end
    rst = 1;
    #1;
    vecs++;
    if (arbt_active !== 1'b0 || proto_err !== 1'b0) begin
      errs++; $display("FAIL rm_async: active=%b perr=%b want 0 0", arbt_active, proto_err);
    end
    #1 rst = 0;
    step();
    o_rsp_valid = 1;
    #2;
    vecs++;
    if (r0_rsp_valid !== 1'b0 || o_rsp_ready !== 1'b1) begin
      errs++; $display("FAIL rm_late_rsp: r0_rv=%b ordy=%b want 0 1", r0_rsp_valid, o_rsp_ready);
    end
    step();
    o_rsp_valid = 0;
    r0_cmd_valid = 1; r1_cmd_valid = 1; r1_cmd_addr = 16'h0400;
    #1;
    vecs++;
    if (proto_err !== 1'b1 || r0_cmd_ready !== 1'b1 || r1_cmd_ready !== 1'b0 || o_cmd_addr !== 16'h0300) begin
      errs++; $display("FAIL rm_regrant: perr=%b rdy=%b%b addr=%h want 1 r0 0300",
                       proto_err, r0_cmd_ready, r1_cmd_ready, o_cmd_addr);
    end
    step();
    r0_cmd_valid = 0; r1_cmd_valid = 0; o_rsp_valid = 1;
    #2;
    vecs++;
    if (r0_rsp_valid !== 1'b1) begin
      errs++; $display("FAIL rm_rsp: r0_rv=%b want 1", r0_rsp_valid);
    end
    step();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_r1_read_r0_write();
    test_stall();
    test_rsp_backpressure();
    test_proto_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  // hard stop in case a task ever stalls
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
